// File: rtl/exec_pkg.sv
// Shared constants and types for the execute-stage multiply controller.
package exec_pkg;

  localparam int unsigned XLEN      = 64;
  localparam int unsigned ALU_W     = 4;
  localparam int unsigned MUL_ITERS = 64;
  localparam int unsigned CNT_W     = 7;

  localparam logic [ALU_W-1:0] ALU_AND = 4'b0000;
  localparam logic [ALU_W-1:0] ALU_ORR = 4'b0001;
  localparam logic [ALU_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [ALU_W-1:0] ALU_SUB = 4'b0110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/iter_cnt.sv
// Iteration counter for the shift-add multiplier: clear, enable, terminal count.
module iter_cnt
  import exec_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear has priority over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == CNT_W'(MUL_ITERS - 1));

endmodule

// File: rtl/exec_mul_ctrl.sv
// Shift-add multiplier controller that borrows the execute-stage ALU adder.
// Optional build macro: MUL_EARLY_EXIT_EN (stop once the remaining multiplier is zero).
module exec_mul_ctrl
  import exec_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [XLEN-1:0]  op_a,
  input  logic [XLEN-1:0]  op_b,
  input  logic [XLEN-1:0]  alu_result,
  output logic [XLEN-1:0]  alu_a,
  output logic [XLEN-1:0]  alu_b,
  output logic [ALU_W-1:0] alu_ctrl,
  output logic             alu_own,
  output logic             stall,
  output logic             done,
  output logic [XLEN-1:0]  product
);

  mul_state_e      state_q, state_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0] mplier_q, mplier_d;
  logic [XLEN-1:0] product_q, product_d;
  logic            cnt_clr, cnt_en, cnt_tc;
  logic            run_exit;
  logic            start_to_done;

  iter_cnt u_iter_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .tc    (cnt_tc)
  );

`ifdef MUL_EARLY_EXIT_EN
  // Finish as soon as no multiplier bits remain; a zero multiplier skips RUN.
  assign run_exit      = cnt_tc || ((mplier_q >> 1) == '0);
  assign start_to_done = (op_b == '0);
`else
  assign run_exit      = cnt_tc;
  assign start_to_done = 1'b0;
`endif

  // Next-state, datapath updates and ALU/pipeline control.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    product_d = product_q;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    alu_a     = '0;
    alu_b     = '0;
    alu_ctrl  = '0;
    alu_own   = 1'b0;
    stall     = 1'b0;
    done      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Held low while reset is asserted so every output reads zero.
        stall = start & reset;
        if (start && !abort) begin
          mcand_d  = op_a;
          mplier_d = op_b;
          acc_d    = '0;
          cnt_clr  = 1'b1;
          if (start_to_done) begin
            state_d   = ST_DONE;
            product_d = '0;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        stall    = 1'b1;
        alu_own  = 1'b1;
        alu_a    = acc_q;
        alu_b    = mplier_q[0] ? mcand_q : '0;
        alu_ctrl = ALU_ADD;
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          acc_d    = alu_result;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_en   = 1'b1;
          if (run_exit) begin
            state_d   = ST_DONE;
            product_d = alu_result;
          end
        end
      end
      ST_DONE: begin
        done    = !abort;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      product_q <= product_d;
    end
  end

  assign product = product_q;

endmodule

// File: tb/tb_exec_mul_ctrl.sv
// Self-checking bench for exec_mul_ctrl with a behavioural multiply model.
module tb_exec_mul_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic        abort;
  logic [63:0] op_a, op_b, alu_result;
  logic [63:0] alu_a, alu_b;
  logic [3:0]  alu_ctrl;
  logic        alu_own, stall, done;
  logic [63:0] product;

  int checks   = 0;
  int failures = 0;
  logic [63:0] last_prod;

  exec_mul_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .op_a       (op_a),
    .op_b       (op_b),
    .alu_result (alu_result),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ctrl   (alu_ctrl),
    .alu_own    (alu_own),
    .stall      (stall),
    .done       (done),
    .product    (product)
  );

  // Execute-stage ALU stand-in: only addition is exercised.
  assign alu_result = (alu_ctrl == 4'b0010) ? (alu_a + alu_b) : 64'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Cycles from start acceptance to the done pulse.
  function automatic int exp_lat(input logic [63:0] b);
`ifdef MUL_EARLY_EXIT_EN
    for (int i = 63; i >= 0; i--) begin
      if (b[i]) return i + 2;
    end
    return 1;
`else
    return 65;
`endif
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_alu_own"}, 64'(alu_own), 64'h0);
    check({tag, "_stall"}, 64'(stall), 64'h0);
    check({tag, "_done"}, 64'(done), 64'h0);
    check({tag, "_alu_a"}, alu_a, 64'h0);
    check({tag, "_alu_b"}, alu_b, 64'h0);
    check({tag, "_alu_ctrl"}, 64'(alu_ctrl), 64'h0);
    check({tag, "_product"}, product, 64'h0);
  endtask

  // One full multiply; optionally pulses start with junk operands mid-RUN.
  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp_p,
                        input string tag, input bit noisy);
    int   want, lat;
    logic seen, run_ok;
    want   = exp_lat(b);
    lat    = 0;
    seen   = 1'b0;
    run_ok = 1'b1;
    @(negedge clk);
    op_a = a; op_b = b; start = 1'b1; abort = 1'b0;
    #1 check({tag, "_stall_idle"}, 64'(stall), 64'h1);
    @(negedge clk);
    start = 1'b0;
    op_a  = {$urandom, $urandom};
    op_b  = {$urandom, $urandom};
    for (int c = 1; c <= 200; c++) begin
      if (noisy) start = (c >= 5 && c <= 10);
      #1;
      if (done) begin
        lat  = c;
        seen = 1'b1;
        break;
      end
      if (!(alu_own && stall && alu_ctrl == 4'b0010)) run_ok = 1'b0;
      if (c == 1) begin
        check({tag, "_alu_a_first"}, alu_a, 64'h0);
        check({tag, "_alu_b_first"}, alu_b, b[0] ? a : 64'h0);
      end
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, "_done_seen"}, 64'(seen), 64'h1);
    check({tag, "_latency"}, 64'(lat), 64'(want));
    check({tag, "_run_ctrl"}, 64'(run_ok), 64'h1);
    check({tag, "_product"}, product, exp_p);
    check({tag, "_stall_done"}, 64'(stall), 64'h0);
    check({tag, "_own_done"}, 64'(alu_own), 64'h0);
    @(negedge clk);
    #1 check({tag, "_done_pulse"}, 64'(done), 64'h0);
    check({tag, "_own_after"}, 64'(alu_own), 64'h0);
    last_prod = exp_p;
  endtask

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] p;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [63:0] ra, rb;
    logic        got_done;

    vecs[0] = '{64'd3, 64'd5, 64'd15};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE};
    vecs[2] = '{64'd0, 64'h1234, 64'd0};
    vecs[3] = '{64'h1234, 64'd0, 64'd0};
    vecs[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1};
    vecs[5] = '{64'h1_0000_0000, 64'h1_0000_0000, 64'd0};
    vecs[6] = '{64'd12345, 64'd67890, 64'd838102050};
    vecs[7] = '{64'd5, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000};

    reset = 1'b0; start = 1'b1; abort = 1'b0;
    op_a = 64'd3; op_b = 64'd5; last_prod = 64'h0;
    #1 check_all_zero("reset_hold");
    repeat (3) @(negedge clk);
    check_all_zero("reset_clocked");
    reset = 1'b1; start = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].p, $sformatf("vec%0d", i), 1'b0);
    end

    // Abort at RUN cycle 10: no done, product kept, then a clean restart.
    @(negedge clk);
    op_a = 64'd5; op_b = 64'h8000_0000_0000_0003; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #1 check("abort_in_run", 64'(alu_own), 64'h1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    #1 check("abort_idle_own", 64'(alu_own), 64'h0);
    check("abort_idle_stall", 64'(stall), 64'h0);
    got_done = 1'b0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (done) got_done = 1'b1;
    end
    check("abort_no_done", 64'(got_done), 64'h0);
    check("abort_product_kept", product, last_prod);
    run_op(64'd7, 64'd9, 64'd63, "after_abort", 1'b0);

    // Reset at RUN cycle 20 clears outputs immediately.
    @(negedge clk);
    op_a = 64'd9; op_b = 64'h8000_0000_0000_0001; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    #1 check("pre_reset_run", 64'(alu_own), 64'h1);
    reset = 1'b0;
    #1 check_all_zero("mid_reset");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1 check("post_reset_idle", 64'(alu_own), 64'h0);

    // Start together with abort in IDLE never enters RUN.
    op_a = 64'd3; op_b = 64'd5; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    got_done = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1 if (alu_own || done) got_done = 1'b1;
      @(negedge clk);
    end
    check("start_abort_ignored", 64'(got_done), 64'h0);

    // Start re-asserted mid-RUN with other operands is ignored.
    run_op(64'd11, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_000B, "start_in_run", 1'b1);

    // Random operands against plain modulo-2^64 multiplication.
    for (int i = 0; i < 20; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom} >> $urandom_range(0, 63);
      run_op(ra, rb, ra * rb, $sformatf("rand%0d", i), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/exec_mul_ctrl.md
EXEC_MUL_CTRL -- requirements
Module: exec_mul_ctrl

Interface
REQ-001 Parameters: none; all constants come from exec_pkg.
REQ-002 clk  input  1  rising-edge clock, the only clock.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request a multiply; sampled only in IDLE.
REQ-005 abort  input  1  pipeline flush; cancels the operation in progress.
REQ-006 op_a  input  64  multiplicand, captured on start.
REQ-007 op_b  input  64  multiplier, captured on start.
REQ-008 alu_result  input  64  result returned by the execute-stage ALU.
REQ-009 alu_a  output  64  ALU operand A while the block owns the ALU.
REQ-010 alu_b  output  64  ALU operand B while the block owns the ALU.
REQ-011 alu_ctrl  output  4  ALU opcode; ALU_ADD while in RUN.
REQ-012 alu_own  output  1  high when the block owns the ALU; the pipeline steers the ALU inputs from this block when high.
REQ-013 stall  output  1  freezes upstream pipeline stages.
REQ-014 done  output  1  one-cycle pulse; product is valid.
REQ-015 product  output  64  low 64 bits of op_a*op_b.

Function
REQ-016 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-017 In IDLE with start=1 and abort=0: capture mcand=op_a, mplier=op_b, acc=0, cnt=0, then go to RUN.
REQ-018 In RUN each cycle the block SHALL drive:
- alu_a=acc
- alu_b=mplier[0] ? mcand : 0
- alu_ctrl=ALU_ADD
- alu_own=1
REQ-019 In RUN, at each clock edge: acc<=alu_result; mcand<=mcand<<1; mplier<=mplier>>1 (logical); cnt<=cnt+1.
REQ-020 RUN SHALL exit to DONE after the iteration in which cnt reaches MUL_ITERS-1 (64 iterations).
REQ-021 DONE SHALL last exactly one cycle: done=1, then go to IDLE.
REQ-022 product SHALL be a register holding acc, updated on entry to DONE and held until the next DONE; arithmetic is modulo 2^64 (identical for signed and unsigned operands).
REQ-023 stall SHALL equal 1 in RUN, and 1 in IDLE when start=1 (combinational); it SHALL be 0 in DONE.
REQ-024 Outside RUN: alu_own=0, alu_a=0, alu_b=0, alu_ctrl=0.
REQ-025 abort=1 in RUN or DONE SHALL return the FSM to IDLE next cycle, with no done pulse and product unchanged.
REQ-026 abort=1 together with start=1 in IDLE: abort wins and the start is ignored.
REQ-027 start asserted in RUN or DONE SHALL be ignored (no queueing).
REQ-028 Latency without the early-exit feature: start accepted at cycle 0, done at cycle 65.

Reset
REQ-029 reset=0 SHALL force, asynchronously, state=IDLE and acc, mcand, mplier, cnt, product=0.
REQ-030 During and after reset, all outputs SHALL be 0; a reset mid-RUN discards the operation.

Configuration
REQ-031 Macro MUL_EARLY_EXIT_EN. Defined: RUN exits to DONE after any iteration whose shifted mplier is 0; a start with op_b=0 goes directly IDLE->DONE with product=0.
REQ-032 MUL_EARLY_EXIT_EN undefined: always exactly 64 RUN cycles.

Structure
REQ-033 exec_pkg SHALL hold the ALU opcode constants (ALU_ADD=4'b0010, ALU_AND, ALU_ORR, ALU_SUB), MUL_ITERS=64, and the state enum type.
REQ-034 One sub-module, iter_cnt (7-bit counter with clear/enable and terminal-count output), SHALL provide cnt.

Verification
REQ-035 op_a=3, op_b=5, no macro -> done at cycle 65 with product=15; alu_own=1 and stall=1 for cycles 1..64.
REQ-036 op_a=3, op_b=5, with MUL_EARLY_EXIT_EN -> 3 RUN cycles, done at cycle 4 with product=15.
REQ-037 op_a=64'hFFFF_FFFF_FFFF_FFFF, op_b=2 -> product=64'hFFFF_FFFF_FFFF_FFFE (wrap).
REQ-038 abort at RUN cycle 10 -> IDLE next cycle; no done pulse; product keeps its prior value; a new start then yields a correct result.
REQ-039 reset=0 at RUN cycle 20 -> all outputs 0 immediately; start in IDLE with abort=1 -> no RUN entry.
REQ-040 op_b=0 with the macro -> done one cycle after start with product=0; start asserted during RUN -> ignored.
